// File: rtl/mod_mul_pkg.sv
// Shared constants and types for the mod (2^24 - 3) multiplier.
package mod_mul_pkg;

    localparam int unsigned MM_W  = 24;
    localparam int unsigned MM_PW = 48;
    localparam int unsigned MM_C  = 3;
    localparam logic [MM_W-1:0] MM_P = 24'hFFFFFD;

    // Widths of the intermediate fold results
    localparam int unsigned MM_S1W = 27;
    localparam int unsigned MM_S2W = 25;

    typedef logic [MM_W-1:0]  mm_word_t;
    typedef logic [MM_PW-1:0] mm_prod_t;

endpackage

// File: rtl/mod_mul_if.sv
// Operand/result bundle for the modular multiplier.
interface mod_mul_if;
    import mod_mul_pkg::*;

    mm_word_t a;
    mm_word_t b;
    mm_word_t m;

    modport master (output a, output b, input m);
    modport slave  (input a, input b, output m);

endinterface

// File: rtl/mod_mul_fold_p24.sv
// Reduces a 48-bit product modulo 2^24 - 3 using two folds with 2^24 == 3.
module mod_mul_fold_p24
    import mod_mul_pkg::*;
(
    input  mm_prod_t prod,
    output mm_word_t res_c
);

    logic [MM_S1W-1:0] s1;
    logic [MM_S2W-1:0] s2;
    logic [MM_S2W-1:0] s3;
    logic [MM_S2W-1:0] s4;
    logic              unused_s4_msb;

    // First fold: 3*H + L, H < 2^24 so the sum fits in 27 bits
    always_comb begin
        s1 = MM_S1W'(MM_C) * MM_S1W'(prod[MM_PW-1:MM_W])
           + MM_S1W'(prod[MM_W-1:0]);
    end

    // Second fold: H1 is at most 3 bits, sum stays below 2^25
    always_comb begin
        s2 = MM_S2W'(MM_C) * MM_S2W'(s1[MM_S1W-1:MM_W])
           + MM_S2W'(s1[MM_W-1:0]);
    end

    // Two conditional subtractions guarantee the result lands below P
    always_comb begin
        s3 = s2;
        if (s2 >= MM_S2W'(MM_P)) begin
            s3 = s2 - MM_S2W'(MM_P);
        end
        s4 = s3;
        if (s3 >= MM_S2W'(MM_P)) begin
            s4 = s3 - MM_S2W'(MM_P);
        end
    end

    assign res_c         = s4[MM_W-1:0];
    assign unused_s4_msb = s4[MM_S2W-1];

endmodule

// File: rtl/mod_mul.sv
// Combinational (a*b) mod (2^24 - 3); clk and reset are reserved and never touch m.
module mod_mul
    import mod_mul_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mod_mul_if.slave     bus
);

    mm_prod_t prod;
    mm_word_t res_c;
    logic     unused_ctrl;

    always_comb begin
        prod = MM_PW'(bus.a) * MM_PW'(bus.b);
    end

    mod_mul_fold_p24 u_fold (
        .prod  (prod),
        .res_c (res_c)
    );

    assign bus.m = res_c;

    // Reserved control pins are sunk here so they cannot reach the datapath
    assign unused_ctrl = clk ^ reset;

endmodule

// File: tb/tb_mod_mul.sv
// Scoreboard bench for mod_mul: stimulus queues expectations, a monitor compares on each sample strobe.
module tb_mod_mul;
    import mod_mul_pkg::*;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    bit   clk_run = 1'b0;

    mod_mul_if bus ();

    mod_mul dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 if (clk_run) clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [23:0] exp_q [$];
    string       name_q [$];
    event        sample_ev;

    function automatic logic [23:0] ref_mod(input logic [23:0] x, input logic [23:0] y);
        logic [47:0] p;
        p = 48'(x) * 48'(y);
        return 24'(p % 48'hFFFFFD);
    endfunction

    // Queue an expectation for the current inputs and strobe the monitor 10 units later
    task automatic expect_m(input logic [23:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        #10;
        -> sample_ev;
        #1;
    endtask

    task automatic apply(input logic [23:0] x, input logic [23:0] y,
                         input logic [23:0] e, input string nm);
        bus.a = x;
        bus.b = y;
        expect_m(e, nm);
    endtask

    // Monitor: pops the oldest expectation on every strobe
    initial begin : monitor
        logic [23:0] e;
        string       nm;
        forever begin
            @(sample_ev);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_without_expectation: m=%h", bus.m);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (bus.m !== e) begin
                    errors++;
                    $display("FAIL %s: a=%h b=%h m=%h expected %h", nm, bus.a, bus.b, bus.m, e);
                end
                checks++;
                if (!(bus.m < 24'hFFFFFD)) begin
                    errors++;
                    $display("FAIL %s_range: m=%h expected below fffffd", nm, bus.m);
                end
            end
        end
    end

    initial begin : stimulus
        logic [23:0] x;
        logic [23:0] y;

        bus.a = '0;
        bus.b = '0;
        #2;

        // Reset held low: output must still track inputs
        apply(24'hF0F0F0, 24'h0F0F0F, 24'h76B2EE, "in_reset_f0f0f0");
        for (int i = 0; i < 8; i++) begin
            reset = 1'($urandom);
            clk   = ~clk;
            #1;
            clk   = ~clk;
            expect_m(24'h76B2EE, "reset_clk_toggle");
        end
        reset = 1'b1;
        clk   = 1'b0;
        expect_m(24'h76B2EE, "after_deassert");

        // Directed vectors (hand-reduced: 0xFFFFFE == 1, 0xFFFFFF == 2, 2^24 == 3)
        apply(24'h000000, 24'h123456, 24'h000000, "zero");
        apply(24'h000001, 24'hFFFFFE, 24'h000001, "ident_unreduced");
        apply(24'hFFFFFD, 24'h000001, 24'h000000, "a_eq_p");
        apply(24'hFFFFFE, 24'h000001, 24'h000001, "a_p_plus1");
        apply(24'h000001, 24'hFFFFFC, 24'hFFFFFC, "max_residue");
        apply(24'hFFFFFF, 24'hFFFFFF, 24'h000004, "max_operands");
        apply(24'h800000, 24'h000002, 24'h000003, "two_pow_24");
        apply(24'h000002, 24'hFFFFFF, 24'h000004, "two_times_ffffff");
        apply(24'hFFFFFD, 24'hFFFFFD, 24'h000000, "p_times_p");
        apply(24'hF0F0F0, 24'h0F0F0F, 24'h76B2EE, "f0f0f0_out_of_reset");

        // Sweep of consecutive a across the 24-bit wrap, clk idle
        x = 24'hFFFFD0;
        y = 24'h0F0F0F;
        for (int i = 0; i < 100; i++) begin
            apply(x, y, ref_mod(x, y), "sweep");
            x = x + 24'd1;
            if (x == 24'h000000) y = y + 24'd1;
        end

        // Random operands against the 48-bit reference, clock running and reset jittering
        clk_run = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            x = 24'($urandom);
            y = 24'($urandom);
            if ((i % 97) == 0) reset = ~reset;
            apply(x, y, ref_mod(x, y), "random");
        end
        clk_run = 1'b0;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
